// File: rtl/bcd_2digit_display_scan.sv
// rtl/bcd_2digit_display_scan.sv - 2-digit multiplexed 7-segment scan driver with frame snapshot and TC stretch
module bcd_2digit_display_scan #(
    parameter int SCAN_DIV = 16,
    parameter int TC_HOLD  = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] Q0,
    input  logic [3:0] Q1,
    input  logic       tc2,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       tc_led
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(TC_HOLD + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(TC_HOLD);

    logic [DW-1:0] div_cnt;
    logic          sel;
    logic [3:0]    snap0;
    logic [3:0]    snap1;
    logic          snap_blz;
    logic [HW-1:0] hold_cnt;
    logic [3:0]    digit;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = 7'h3F;
            4'd1:    bcd_to_seg = 7'h06;
            4'd2:    bcd_to_seg = 7'h5B;
            4'd3:    bcd_to_seg = 7'h4F;
            4'd4:    bcd_to_seg = 7'h66;
            4'd5:    bcd_to_seg = 7'h6D;
            4'd6:    bcd_to_seg = 7'h7D;
            4'd7:    bcd_to_seg = 7'h07;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h6F;
            default: bcd_to_seg = 7'b1000000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt  <= '0;
            sel      <= 1'b0;
            snap0    <= 4'd0;
            snap1    <= 4'd0;
            snap_blz <= 1'b0;
            hold_cnt <= '0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                sel     <= ~sel;
                // Latch digits only at the end of the tens phase so a frame never mixes old and new values
                if (sel) begin
                    snap0    <= Q0;
                    snap1    <= Q1;
                    snap_blz <= blank_lz;
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end

            if (tc2) begin
                hold_cnt <= HOLD_LOAD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

    always_comb begin
        digit  = sel ? snap1 : snap0;
        an     = sel ? 2'b01 : 2'b10;
        tc_led = (hold_cnt != '0);
        if (sel && snap_blz && (snap1 == 4'd0)) begin
            seg = 7'h00;
        end else begin
            seg = bcd_to_seg(digit);
        end
    end

endmodule

// File: tb/tb_bcd_2digit_display_scan.sv
// tb/tb_bcd_2digit_display_scan.sv - directed self-checking bench for bcd_2digit_display_scan
module tb_bcd_2digit_display_scan;

    logic       clk;
    logic       rstn;
    logic [3:0] Q0;
    logic [3:0] Q1;
    logic       tc2;
    logic       blank_lz;
    logic [6:0] seg;
    logic [1:0] an;
    logic       tc_led;

    int checks;
    int failures;

    bcd_2digit_display_scan #(
        .SCAN_DIV(4),
        .TC_HOLD (3)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .Q0      (Q0),
        .Q1      (Q1),
        .tc2     (tc2),
        .blank_lz(blank_lz),
        .seg     (seg),
        .an      (an),
        .tc_led  (tc_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rstn     = 1'b0;
        Q0       = 4'd3;
        Q1       = 4'd7;
        tc2      = 1'b0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (an !== 2'b10 || seg !== 7'h3F || tc_led !== 1'b0) begin
            failures++;
            $display("FAIL reset: an=%b seg=%h tc_led=%b, want an=10 seg=3f tc_led=0", an, seg, tc_led);
        end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [4];
        exp_seg = '{7'h3F, 7'h3F, 7'h4F, 7'h07};
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            checks++;
            if (an !== (((c / 4) % 2) ? 2'b01 : 2'b10) || seg !== exp_seg[c / 4]) begin
                failures++;
                $display("FAIL scan c=%0d: an=%b seg=%h, want an=%b seg=%h", c, an, seg,
                         (((c / 4) % 2) ? 2'b01 : 2'b10), exp_seg[c / 4]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_tear_free();
        logic [6:0] exp_seg [4];
        exp_seg = '{7'h4F, 7'h07, 7'h6D, 7'h5B};
        for (int c = 0; c < 16; c++) begin
            if (c == 1) Q1 = 4'd2;
            if (c == 5) Q0 = 4'd5;
            #1;
            checks++;
            if (an !== (((c / 4) % 2) ? 2'b01 : 2'b10) || seg !== exp_seg[c / 4]) begin
                failures++;
                $display("FAIL tear c=%0d: an=%b seg=%h, want an=%b seg=%h", c, an, seg,
                         (((c / 4) % 2) ? 2'b01 : 2'b10), exp_seg[c / 4]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_invalid_bcd();
        logic [6:0] exp_seg [4];
        exp_seg = '{7'h6D, 7'h5B, 7'h40, 7'h40};
        Q0 = 4'hF;
        Q1 = 4'hC;
        for (int c = 0; c < 16; c++) begin
            #1;
            checks++;
            if (an !== (((c / 4) % 2) ? 2'b01 : 2'b10) || seg !== exp_seg[c / 4]) begin
                failures++;
                $display("FAIL invalid c=%0d: an=%b seg=%h, want an=%b seg=%h", c, an, seg,
                         (((c / 4) % 2) ? 2'b01 : 2'b10), exp_seg[c / 4]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blank_lz();
        logic [6:0] exp_seg [8];
        exp_seg = '{7'h40, 7'h40, 7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F, 7'h3F};
        Q0       = 4'd8;
        Q1       = 4'd0;
        blank_lz = 1'b1;
        for (int c = 0; c < 32; c++) begin
            if (c == 16) blank_lz = 1'b0;
            #1;
            checks++;
            if (an !== (((c / 4) % 2) ? 2'b01 : 2'b10) || seg !== exp_seg[c / 4]) begin
                failures++;
                $display("FAIL blank c=%0d: an=%b seg=%h, want an=%b seg=%h", c, an, seg,
                         (((c / 4) % 2) ? 2'b01 : 2'b10), exp_seg[c / 4]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_tc_single();
        logic [15:0] exp_led;
        exp_led = 16'h000E;
        tc2 = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++;
            if (tc_led !== exp_led[k]) begin
                failures++;
                $display("FAIL tc_single k=%0d: tc_led=%b, want %b", k, tc_led, exp_led[k]);
            end
            tc2 = (k == 0);
            @(negedge clk);
        end
        tc2 = 1'b0;
    endtask

    task automatic test_tc_retrigger();
        logic [15:0] exp_led;
        exp_led = 16'h003E;
        tc2 = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++;
            if (tc_led !== exp_led[k]) begin
                failures++;
                $display("FAIL tc_retrigger k=%0d: tc_led=%b, want %b", k, tc_led, exp_led[k]);
            end
            tc2 = (k == 0) || (k == 2);
            @(negedge clk);
        end
        tc2 = 1'b0;
    endtask

    task automatic test_tc_held();
        logic [15:0] exp_led;
        exp_led = 16'h01FE;
        tc2 = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 14; k++) begin
            #1;
            checks++;
            if (tc_led !== exp_led[k]) begin
                failures++;
                $display("FAIL tc_held k=%0d: tc_led=%b, want %b", k, tc_led, exp_led[k]);
            end
            tc2 = (k < 6);
            @(negedge clk);
        end
        tc2 = 1'b0;
    endtask

    task automatic test_async_reset();
        rstn = 1'b0;
        Q0   = 4'd4;
        Q1   = 4'd9;
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tc2 = (c == 2);
            @(negedge clk);
        end
        tc2 = 1'b0;
        #1;
        checks++;
        if (an !== 2'b01 || tc_led !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: an=%b tc_led=%b, want an=01 tc_led=1", an, tc_led);
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (an !== 2'b10 || seg !== 7'h3F || tc_led !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: an=%b seg=%h tc_led=%b, want an=10 seg=3f tc_led=0", an, seg, tc_led);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_scan();
        test_tear_free();
        test_invalid_bcd();
        test_blank_lz();
        test_tc_single();
        test_tc_retrigger();
        test_tc_held();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_2digit_display_scan.md
Name: bcd_2digit_display_scan

Overview:
- Downstream consumer of the 2-digit cascadable BCD counter: takes its ones digit, tens digit and terminal-count output.
- Drives a 2-digit multiplexed common-anode 7-segment display, refreshing the digits alternately from a clock-divided scan counter.
- Digit values are snapshotted once per scan frame, so a counter update mid-frame never tears the display.
- Stretches the single-cycle terminal-count pulse into a visible LED indication.

Parameters:
- SCAN_DIV, 16, clock cycles each digit stays lit (legal range 2..65536).
- TC_HOLD, 8, clock cycles the tc_led stays high after a tc2 pulse (legal range 1..65535).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- Q0  input  4  ones BCD digit from the counter.
- Q1  input  4  tens BCD digit from the counter.
- tc2  input  1  terminal-count pulse from the counter.
- blank_lz  input  1  1 = blank the tens digit when it is 0.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- an  output  2  digit anodes, active-low; an[0] = ones, an[1] = tens.
- tc_led  output  1  stretched terminal-count indicator.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Registers are div_cnt, sel, snap0, snap1, snap_blz and hold_cnt. All of them clear to 0 asynchronously while rstn = 0.
- seg, an and tc_led are combinational decodes of registers only. There is no combinational path from any input to any output.
- Reset output values: an = 2'b10, seg = 7'b0111111 (digit 0), tc_led = 0.
- Scan counter (div_cnt):
  - Increments every cycle.
  - At SCAN_DIV-1 it wraps to 0 and sel toggles on the same edge.
  - sel = 0 shows the ones digit: an = 2'b10, digit = snap0.
  - sel = 1 shows the tens digit: an = 2'b01, digit = snap1.
  - Each digit is lit for exactly SCAN_DIV cycles; a full frame is 2*SCAN_DIV cycles.
- Snapshot:
  - On the edge where div_cnt = SCAN_DIV-1 and sel = 1 (the frame boundary), load snap0 <= Q0, snap1 <= Q1, snap_blz <= blank_lz.
  - At no other edge do these registers change.
  - Input changes become visible at the next frame boundary; worst-case latency is 2*SCAN_DIV cycles.
- Decode:
  - 0..9 map to the standard patterns: 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F (hex, {g..a}).
  - Any value 10..15 displays a dash: seg = 7'b1000000.
- Leading-zero blank: when sel = 1, snap_blz = 1 and snap1 = 0, seg = 0. an is still driven to 2'b01, so scan timing is unchanged. The ones digit is never blanked.
- TC stretch (hold_cnt):
  - On an edge with tc2 = 1, hold_cnt <= TC_HOLD.
  - Otherwise, if hold_cnt != 0, it decrements.
  - tc_led = (hold_cnt != 0).
  - A single-cycle tc2 pulse gives tc_led high for exactly TC_HOLD cycles, starting the cycle after the sampling edge.
  - tc2 arriving again while the LED is held reloads hold_cnt (retrigger, no accumulation).
  - tc2 held high keeps tc_led high continuously.
- Reset mid-operation: all registers clear immediately, regardless of clk. After release the display shows 0 on the ones digit until the first frame boundary, which occurs at cycle 2*SCAN_DIV-1 after release.
- Exactly one anode is active in every cycle after reset; an = 2'b00 or 2'b11 is illegal.

Test Plan:
- Reset/scan, SCAN_DIV=4: release rstn with Q0 = 3, Q1 = 7 -> an = 10 for cycles 0-3 with seg = 3F, then an = 01 for 4-7 with seg = 3F, then an = 10 with seg = 4F (3) and an = 01 with seg = 07 (7). The anode pattern repeats every 8 cycles.
- Tear-free snapshot: change Q0 from 3 to 5 midway through a tens phase -> seg for the ones digit stays 4F until the next frame boundary, then shows 6D. No intermediate value appears.
- Invalid BCD: Q1 = 4'hC -> tens digit shows seg = 40. Q0 = 4'hF -> ones digit shows 40.
- Leading-zero blanking: Q1 = 0, Q0 = 8, blank_lz = 1 -> during the tens phase an = 01, seg = 00; during the ones phase seg = 7F. With blank_lz = 0 the tens phase shows seg = 3F.
- TC stretch, TC_HOLD=3:
  - 1-cycle tc2 pulse -> tc_led high for exactly 3 cycles.
  - A second pulse 2 cycles after the first -> tc_led stays high for a total of 5 cycles.
  - tc2 held for 6 cycles -> tc_led high for 8 cycles.
- Async reset mid-frame: assert rstn low between clock edges while the tens digit is lit and tc_led = 1 -> an = 10, seg = 3F and tc_led = 0 immediately, without waiting for a clk edge.
